width_packer_n: RTL
===================

Name: width_packer_n

Overview:
- Parametrised successor of the team's 8b->32b lane assembler.
- Packs RATIO consecutive IN_W-bit beats into one IN_W*RATIO-bit word, on a single clock domain (clk_4f).
- Adds what the previous block lacked: downstream backpressure, tolerance of valid gaps, flush of partial words with a lane count, and a selectable lane order.
- Sits between the byte-wide receive path and the word-wide FIFOs.

Parameters:
- IN_W, 8, width of one input beat in bits (>=1).
- RATIO, 4, beats per output word (>=2). OUT_W = IN_W*RATIO.
- MSB_FIRST, 1, 1 = first beat lands in data_out[OUT_W-1 -: IN_W]; 0 = first beat lands in data_out[IN_W-1:0].
- DROP_ON_GAP, 0, 1 = a valid_in-low cycle while a word is partially filled discards it; 0 = gaps are held.

Ports:
- clk_4f  in  1  beat clock; all state updates on its rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- data_in  in  IN_W  input beat.
- valid_in  in  1  beat present on data_in.
- flush  in  1  emit the current partial word.
- ready_out  in  1  downstream accepts data_out this cycle.
- ready_in  out  1  block accepts a beat/flush this cycle.
- data_out  out  OUT_W  assembled word.
- valid_out  out  1  data_out holds a word.
- lanes_out  out  clog2(RATIO+1)  number of valid lanes in data_out (RATIO for a full word).
- drop_err  out  1  one-cycle pulse: partial word discarded (DROP_ON_GAP=1 only).

Behaviour:
- Reset (reset_L=0, asynchronous):
  - data_out=0, valid_out=0, lanes_out=0, drop_err=0.
  - Lane counter cnt=0, accumulator cleared.
- ready_in = !valid_out || ready_out (combinational).
- A beat is accepted when valid_in && ready_in; a flush is honoured when flush && ready_in.
  - With ready_in=0, upstream holds data_in, valid_in and flush.
- Fill:
  - An accepted beat is written to lane cnt of the accumulator; the lane position follows MSB_FIRST.
  - cnt increments. Unfilled lanes read 0.
- Complete:
  - When the accepted beat fills lane RATIO-1, the next cycle has data_out = full word, valid_out=1, lanes_out=RATIO.
  - cnt returns to 0 and the accumulator is cleared the same edge.
  - Latency from last beat to valid_out: 1 cycle.
- Output handshake:
  - A word is consumed on valid_out && ready_out.
  - With ready_out=0, data_out, valid_out and lanes_out hold.
  - Back-to-back words at full rate are sustained when ready_out stays 1.
- Flush, honoured:
  - Effective count = cnt + (beat accepted this cycle ? 1 : 0). Any same-cycle beat is included first.
  - Effective count 0: no-op, valid_out unaffected by the flush.
  - Effective count 1..RATIO: word loaded with lanes_out = effective count and unfilled lanes zero.
  - cnt is set to 0.
- Gap (valid_in=0, no flush, cnt>0):
  - DROP_ON_GAP=0: state is held indefinitely.
  - DROP_ON_GAP=1: accumulator cleared, cnt=0, drop_err pulses high the next cycle, valid_out unaffected.
  - A gap caused by ready_in=0 is a stall, not a gap: never drops.
- cnt counts from 0 to RATIO-1 only; it never wraps past RATIO-1 without emitting.
- Reset asserted mid-word or with valid_out=1: all state is lost immediately and no word is emitted after release.
- valid_in is only meaningful in cycles where ready_in=1; beats offered with ready_in=0 are not accepted.

Test Plan:
1. IN_W=8, RATIO=4, MSB_FIRST=1, ready_out=1; beats 0xAA,0xBB,0xCC,0xDD on consecutive cycles -> one cycle after 0xDD: data_out=0xAABBCCDD, valid_out=1, lanes_out=4; 8 continuous beats -> two words on consecutive-word cadence.
2. MSB_FIRST=0, same beats -> data_out=0xDDCCBBAA, lanes_out=4.
3. Beats 0x11,0x22, then flush alone -> data_out=0x11220000, lanes_out=2; flush together with beat 0x33 after 0x11,0x22 -> data_out=0x11223300, lanes_out=3; flush with cnt=0 and no beat -> valid_out stays 0.
4. Full word pending with ready_out=0 for 5 cycles, valid_in=1 -> ready_in=0 and data_out stable for all 5 cycles, no beat consumed; ready_out=1 -> word consumed, fill resumes without loss or duplication.
5. DROP_ON_GAP=1: beats 0x01,0x02, one idle cycle, then 0x03..0x06 -> drop_err pulses once, next word=0x03040506; DROP_ON_GAP=0 with the same stimulus -> word 0x01020304, drop_err never asserted.
6. reset_L pulsed low after 3 beats -> outputs 0 immediately; after release, beats 0xA0..0xA3 -> 0xA0A1A2A3, with no stale lanes.

Source files
------------

// File: rtl/width_packer_n.sv
// Packs RATIO consecutive IN_W-bit beats into one OUT_W-bit word with backpressure,
// partial-word flush with lane count, and optional discard of partial words on input gaps.
module width_packer_n #(
    parameter  int IN_W        = 8,
    parameter  int RATIO       = 4,
    parameter  int MSB_FIRST   = 1,
    parameter  int DROP_ON_GAP = 0,
    localparam int OUT_W       = IN_W * RATIO,
    localparam int LW          = $clog2(RATIO + 1)
) (
    input  logic             clk_4f,
    input  logic             reset_L,
    input  logic [IN_W-1:0]  data_in,
    input  logic             valid_in,
    input  logic             flush,
    input  logic             ready_out,
    output logic             ready_in,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_out,
    output logic [LW-1:0]    lanes_out,
    output logic             drop_err
);

    localparam int             CW       = $clog2(RATIO);
    localparam logic [CW-1:0]  CNT_LAST = CW'(RATIO - 1);

    logic [CW-1:0]    cnt_p0;
    logic [OUT_W-1:0] acc_p0;

    logic             beat_acc;
    logic             flush_acc;
    logic             load_word;
    logic             gap_drop;
    logic [LW-1:0]    eff_cnt;
    logic [OUT_W-1:0] acc_nxt;

    // Writes a beat into the lane addressed by the fill counter, honouring lane order.
    function automatic logic [OUT_W-1:0] place_beat(
        input logic [OUT_W-1:0] acc,
        input logic [IN_W-1:0]  beat,
        input logic [CW-1:0]    lane
    );
        logic [OUT_W-1:0] r;
        int               pos;
        r = acc;
        for (int i = 0; i < RATIO; i++) begin
            pos = (MSB_FIRST != 0) ? (RATIO - 1 - i) : i;
            if (lane == CW'(i)) r[pos*IN_W +: IN_W] = beat;
        end
        return r;
    endfunction

    assign ready_in = !valid_out || ready_out;

    always_comb begin
        beat_acc  = valid_in && ready_in;
        flush_acc = flush && ready_in;
        eff_cnt   = LW'(cnt_p0) + LW'(beat_acc);
        acc_nxt   = beat_acc ? place_beat(acc_p0, data_in, cnt_p0) : acc_p0;
        // A same-cycle beat is folded in before a flush takes the word.
        load_word = (beat_acc && (cnt_p0 == CNT_LAST)) || (flush_acc && (eff_cnt != '0));
        // A stall (ready_in low) never counts as a gap.
        gap_drop  = (DROP_ON_GAP != 0) && ready_in && !valid_in && !flush && (cnt_p0 != '0);
    end

    // Stage p0: accumulator/counter update and output word register
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            cnt_p0    <= '0;
            acc_p0    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            lanes_out <= '0;
            drop_err  <= 1'b0;
        end else begin
            drop_err <= 1'b0;
            if (valid_out && ready_out) valid_out <= 1'b0;
            if (load_word) begin
                data_out  <= acc_nxt;
                lanes_out <= eff_cnt;
                valid_out <= 1'b1;
                cnt_p0    <= '0;
                acc_p0    <= '0;
            end else if (beat_acc) begin
                acc_p0 <= acc_nxt;
                cnt_p0 <= cnt_p0 + CW'(1);
            end else if (gap_drop) begin
                acc_p0   <= '0;
                cnt_p0   <= '0;
                drop_err <= 1'b1;
            end
        end
    end

endmodule
